// File: rtl/wr_engine_scheduler_if.sv
// Bundle between the write-engine scheduler, its requesters and the shared
// axi_master_wr engine. master = scheduler side, slave = requesters plus engine.
interface wr_engine_scheduler_if #(
    parameter int NUM_REQ   = 4,
    parameter int CTX_WIDTH = 32
) ();
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*64-1:0]        req_addr;
    logic [NUM_REQ*32-1:0]        req_pattern;
    logic [NUM_REQ*32-1:0]        req_number;
    logic [NUM_REQ*32-1:0]        req_init_data;
    logic [NUM_REQ*CTX_WIDTH-1:0] req_context;
    logic [NUM_REQ-1:0]           req_done;
    logic [NUM_REQ-1:0]           req_error;

    logic                         eng_start_pulse;
    logic [63:0]                  eng_addr;
    logic [31:0]                  eng_pattern;
    logic [31:0]                  eng_number;
    logic [31:0]                  eng_init_data;
    logic [CTX_WIDTH-1:0]         eng_context;
    logic                         eng_done_pulse;
    logic                         eng_error;

    logic                         busy;
    logic [IDX_W-1:0]             grant_idx;

    modport master (
        input  req_valid, req_addr, req_pattern, req_number, req_init_data, req_context,
        input  eng_done_pulse, eng_error,
        output req_ready, req_done, req_error,
        output eng_start_pulse, eng_addr, eng_pattern, eng_number, eng_init_data, eng_context,
        output busy, grant_idx
    );

    modport slave (
        output req_valid, req_addr, req_pattern, req_number, req_init_data, req_context,
        output eng_done_pulse, eng_error,
        input  req_ready, req_done, req_error,
        input  eng_start_pulse, eng_addr, eng_pattern, eng_number, eng_init_data, eng_context,
        input  busy, grant_idx
    );
endinterface

// File: rtl/wr_engine_scheduler.sv
// Round-robin scheduler sharing one axi_master_wr write engine among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining WR_SCHED_TIMEOUT_EN.
module wr_engine_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CTX_WIDTH = 32,
    parameter int TIMEOUT_W = 24
) (
    input  logic                  clk,
    input  logic                  resetn,
    wr_engine_scheduler_if.master bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GRANT    = 3'd1;
    localparam logic [2:0] S_LAUNCH   = 3'd2;
    localparam logic [2:0] S_BUSY     = 3'd3;
    localparam logic [2:0] S_COMPLETE = 3'd4;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    logic [2:0]           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic [NUM_REQ-1:0]   ready_q, ready_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   error_q, error_d;
    logic [63:0]          addr_q, addr_d;
    logic [31:0]          pattern_q, pattern_d;
    logic [31:0]          number_q, number_d;
    logic [31:0]          init_q, init_d;
    logic [CTX_WIDTH-1:0] ctx_q, ctx_d;

    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_found;
    logic [IDX_W:0]       scan_idx;
    logic [IDX_W-1:0]     scan_slot;
    logic [NUM_REQ-1:0]   grant_oh;

`ifdef WR_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] timer_q, timer_d;
`endif

    // Scan starts one past the last winner so no slot can win twice while another waits.
    always_comb begin
        pick_idx   = rr_ptr_q;
        pick_found = 1'b0;
        scan_idx   = '0;
        scan_slot  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (scan_idx >= (IDX_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (IDX_W+1)'(NUM_REQ);
            end
            scan_slot = scan_idx[IDX_W-1:0];
            if (!pick_found && bus.req_valid[scan_slot]) begin
                pick_idx   = scan_slot;
                pick_found = 1'b1;
            end
        end
    end

    assign grant_oh = ONE_HOT0 << grant_q;

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        err_d     = err_q;
        start_d   = 1'b0;
        ready_d   = '0;
        done_d    = '0;
        error_d   = '0;
        addr_d    = addr_q;
        pattern_d = pattern_q;
        number_d  = number_q;
        init_d    = init_q;
        ctx_d     = ctx_q;
`ifdef WR_SCHED_TIMEOUT_EN
        timer_d   = timer_q;
`endif
        case (state_q)
            S_IDLE: begin
                // Fields are held with valid, so latching on the grant edge sees the same job.
                if (|bus.req_valid) begin
                    grant_d   = pick_idx;
                    ready_d   = ONE_HOT0 << pick_idx;
                    addr_d    = bus.req_addr[64*pick_idx +: 64];
                    pattern_d = bus.req_pattern[32*pick_idx +: 32];
                    number_d  = bus.req_number[32*pick_idx +: 32];
                    init_d    = bus.req_init_data[32*pick_idx +: 32];
                    ctx_d     = bus.req_context[CTX_WIDTH*pick_idx +: CTX_WIDTH];
                    state_d   = S_GRANT;
                end
            end
            S_GRANT: begin
                err_d = 1'b0;
                if (number_q == 32'd0) begin
                    done_d  = grant_oh;
                    state_d = S_COMPLETE;
                end else begin
                    start_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                err_d   = err_q | bus.eng_error;
`ifdef WR_SCHED_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = S_BUSY;
            end
            S_BUSY: begin
                err_d = err_q | bus.eng_error;
                if (bus.eng_done_pulse) begin
                    done_d  = grant_oh;
                    error_d = grant_oh & {NUM_REQ{err_q | bus.eng_error}};
                    state_d = S_COMPLETE;
                end
`ifdef WR_SCHED_TIMEOUT_EN
                else if (&timer_q) begin
                    done_d  = grant_oh;
                    error_d = grant_oh;
                    state_d = S_COMPLETE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            S_COMPLETE: begin
                rr_ptr_d = grant_q;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
            ready_q   <= '0;
            done_q    <= '0;
            error_q   <= '0;
            addr_q    <= '0;
            pattern_q <= '0;
            number_q  <= '0;
            init_q    <= '0;
            ctx_q     <= '0;
`ifdef WR_SCHED_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            error_q   <= error_d;
            addr_q    <= addr_d;
            pattern_q <= pattern_d;
            number_q  <= number_d;
            init_q    <= init_d;
            ctx_q     <= ctx_d;
`ifdef WR_SCHED_TIMEOUT_EN
            timer_q   <= timer_d;
`endif
        end
    end

    assign bus.req_ready       = ready_q;
    assign bus.req_done        = done_q;
    assign bus.req_error       = error_q;
    assign bus.eng_start_pulse = start_q;
    assign bus.eng_addr        = addr_q;
    assign bus.eng_pattern     = pattern_q;
    assign bus.eng_number      = number_q;
    assign bus.eng_init_data   = init_q;
    assign bus.eng_context     = ctx_q;
    assign bus.busy            = busy_q;
    assign bus.grant_idx       = grant_q;
endmodule

// File: tb/tb_wr_engine_scheduler.sv
// Directed bench for wr_engine_scheduler: reset, round-robin order, latency,
// zero-burst, error stickiness, simultaneous error/done and reset mid-job.
module tb_wr_engine_scheduler;
    localparam int NUM_REQ   = 4;
    localparam int CTX_WIDTH = 32;

    logic clk;
    logic resetn;
    int   compared;
    int   mismatched;

    wr_engine_scheduler_if #(.NUM_REQ(NUM_REQ), .CTX_WIDTH(CTX_WIDTH)) bif ();

    wr_engine_scheduler #(.NUM_REQ(NUM_REQ), .CTX_WIDTH(CTX_WIDTH), .TIMEOUT_W(24)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] addrOf(input int slot);
        return 64'hA5A5_0000_0000_1000 + 64'(slot) * 64'h100;
    endfunction

    task automatic applyStimulus(input int slot, input logic [31:0] number);
        bif.req_addr[64*slot +: 64]      = addrOf(slot);
        bif.req_pattern[32*slot +: 32]   = 32'h0000_0306;
        bif.req_number[32*slot +: 32]    = number;
        bif.req_init_data[32*slot +: 32] = 32'h1111_0000 + 32'(slot);
        bif.req_context[32*slot +: 32]   = 32'hC0DE_0000 + 32'(slot);
        bif.req_valid[slot]              = 1'b1;
    endtask

    task automatic pulseDone();
        bif.eng_done_pulse = 1'b1;
        step();
        bif.eng_done_pulse = 1'b0;
    endtask

    task automatic waitReady();
        for (int i = 0; i < 12; i++) begin
            if (|bif.req_ready) break;
            step();
        end
        checkOutput("ready_seen", 64'(|bif.req_ready), 64'd1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        resetn             = 1'b0;
        bif.req_valid      = '0;
        bif.req_addr       = '0;
        bif.req_pattern    = '0;
        bif.req_number     = '0;
        bif.req_init_data  = '0;
        bif.req_context    = '0;
        bif.eng_done_pulse = 1'b0;
        bif.eng_error      = 1'b0;

        step();
        step();
        checkOutput("rst_ready", 64'(bif.req_ready), 64'd0);
        checkOutput("rst_done", 64'(bif.req_done), 64'd0);
        checkOutput("rst_error", 64'(bif.req_error), 64'd0);
        checkOutput("rst_start", 64'(bif.eng_start_pulse), 64'd0);
        checkOutput("rst_busy", 64'(bif.busy), 64'd0);
        checkOutput("rst_grant", 64'(bif.grant_idx), 64'd0);
        checkOutput("rst_addr", bif.eng_addr, 64'd0);
        resetn = 1'b1;
        step();

        $display("[TB] round-robin with all slots valid");
        for (int s = 0; s < NUM_REQ; s++) applyStimulus(s, 32'd2);
        for (int j = 0; j < 5; j++) begin
            waitReady();
            checkOutput("rr_ready", 64'(bif.req_ready), 64'(4'b0001 << (j % 4)));
            checkOutput("rr_grant", 64'(bif.grant_idx), 64'(j % 4));
            checkOutput("rr_addr", bif.eng_addr, addrOf(j % 4));
            if (j == 4) bif.req_valid = '0;
            step();
            checkOutput("rr_start", 64'(bif.eng_start_pulse), 64'd1);
            checkOutput("rr_ready_clr", 64'(bif.req_ready), 64'd0);
            step();
            pulseDone();
            checkOutput("rr_done", 64'(bif.req_done), 64'(4'b0001 << (j % 4)));
            step();
        end

        $display("[TB] single job on slot 2, latency");
        applyStimulus(2, 32'd4);
        step();
        checkOutput("sj_ready", 64'(bif.req_ready), 64'b0100);
        checkOutput("sj_start_early", 64'(bif.eng_start_pulse), 64'd0);
        checkOutput("sj_addr", bif.eng_addr, addrOf(2));
        checkOutput("sj_pattern", 64'(bif.eng_pattern), 64'h306);
        checkOutput("sj_number", 64'(bif.eng_number), 64'd4);
        checkOutput("sj_init", 64'(bif.eng_init_data), 64'h1111_0002);
        checkOutput("sj_ctx", 64'(bif.eng_context), 64'hC0DE_0002);
        bif.req_valid = '0;
        step();
        checkOutput("sj_start", 64'(bif.eng_start_pulse), 64'd1);
        checkOutput("sj_busy", 64'(bif.busy), 64'd1);
        step();
        checkOutput("sj_start_clr", 64'(bif.eng_start_pulse), 64'd0);
        pulseDone();
        checkOutput("sj_done", 64'(bif.req_done), 64'b0100);
        checkOutput("sj_error", 64'(bif.req_error), 64'd0);
        step();
        checkOutput("sj_done_clr", 64'(bif.req_done), 64'd0);
        checkOutput("sj_idle", 64'(bif.busy), 64'd0);
        checkOutput("sj_addr_hold", bif.eng_addr, addrOf(2));

        $display("[TB] zero-burst job on slot 1");
        applyStimulus(1, 32'd0);
        step();
        checkOutput("zb_ready", 64'(bif.req_ready), 64'b0010);
        bif.req_valid = '0;
        step();
        checkOutput("zb_start", 64'(bif.eng_start_pulse), 64'd0);
        checkOutput("zb_done", 64'(bif.req_done), 64'b0010);
        checkOutput("zb_error", 64'(bif.req_error), 64'd0);
        step();
        checkOutput("zb_start2", 64'(bif.eng_start_pulse), 64'd0);
        checkOutput("zb_done_clr", 64'(bif.req_done), 64'd0);

        $display("[TB] error mid-BUSY on slot 3");
        applyStimulus(3, 32'd3);
        step();
        checkOutput("er_ready", 64'(bif.req_ready), 64'b1000);
        bif.req_valid = '0;
        step();
        step();
        bif.eng_error = 1'b1;
        step();
        bif.eng_error = 1'b0;
        step();
        pulseDone();
        checkOutput("er_done", 64'(bif.req_done), 64'b1000);
        checkOutput("er_error", 64'(bif.req_error), 64'b1000);
        step();

        $display("[TB] clean job on slot 0 with stray error before launch");
        applyStimulus(0, 32'd1);
        bif.eng_error = 1'b1;
        step();
        checkOutput("cl_ready", 64'(bif.req_ready), 64'b0001);
        bif.req_valid = '0;
        bif.eng_error = 1'b0;
        step();
        step();
        pulseDone();
        checkOutput("cl_done", 64'(bif.req_done), 64'b0001);
        checkOutput("cl_error", 64'(bif.req_error), 64'd0);
        step();

        $display("[TB] simultaneous error and done on slot 1");
        applyStimulus(1, 32'd5);
        step();
        checkOutput("sm_ready", 64'(bif.req_ready), 64'b0010);
        bif.req_valid = '0;
        step();
        step();
        bif.eng_error = 1'b1;
        pulseDone();
        bif.eng_error = 1'b0;
        checkOutput("sm_done", 64'(bif.req_done), 64'b0010);
        checkOutput("sm_error", 64'(bif.req_error), 64'b0010);
        step();

        $display("[TB] reset mid-BUSY");
        applyStimulus(2, 32'd4);
        step();
        bif.req_valid = '0;
        step();
        step();
        checkOutput("rb_busy", 64'(bif.busy), 64'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        checkOutput("rb_ready", 64'(bif.req_ready), 64'd0);
        checkOutput("rb_done", 64'(bif.req_done), 64'd0);
        checkOutput("rb_start", 64'(bif.eng_start_pulse), 64'd0);
        checkOutput("rb_busy0", 64'(bif.busy), 64'd0);
        checkOutput("rb_addr", bif.eng_addr, 64'd0);
        checkOutput("rb_number", 64'(bif.eng_number), 64'd0);
        pulseDone();
        checkOutput("rb_stale_done", 64'(bif.req_done), 64'd0);
        checkOutput("rb_stale_busy", 64'(bif.busy), 64'd0);
        applyStimulus(0, 32'd2);
        applyStimulus(3, 32'd2);
        step();
        checkOutput("rb_first", 64'(bif.req_ready), 64'b0001);
        bif.req_valid[0] = 1'b0;
        step();
        step();
        pulseDone();
        checkOutput("rb_done0", 64'(bif.req_done), 64'b0001);
        step();
        waitReady();
        checkOutput("rb_second", 64'(bif.req_ready), 64'b1000);
        bif.req_valid = '0;
        step();
        step();
        pulseDone();
        checkOutput("rb_done3", 64'(bif.req_done), 64'b1000);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
